// File: rtl/uart_rx_if.sv
// Receive-side bundle for uart_rx: serial line in, byte holding register
// with VALID/ACK handshake and status flags out.
interface uart_rx_if;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       ack;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    // The receiver is the slave; the consumer drives the line and ACK.
    modport slave (
        input  rxd,
        input  ack,
        output data,
        output valid,
        output overrun,
        output frame_err,
        output busy
    );

    modport master (
        output rxd,
        output ack,
        input  data,
        input  valid,
        input  overrun,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with a fixed divider, one-entry holding
// register with VALID/ACK handshake, sticky overrun and framing-error pulse.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic      clk_i,
    input  logic      rst_i,
    uart_rx_if.slave  rx_if
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK
    } state_t;

    state_t           state_q;
    logic             rxd_m_q;
    logic             rxd_s_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             done_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             overrun_q;
    logic             frame_err_q;
    logic             busy_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rxd_m_q     <= 1'b1;
            rxd_s_q     <= 1'b1;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rxd_m_q     <= rx_if.rxd;
            rxd_s_q     <= rxd_m_q;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (!rxd_s_q) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        if (!rxd_s_q) begin
                            state_q   <= S_DATA;
                            bit_idx_q <= '0;
                        end else begin
                            // Start bit vanished before mid-bit: treat as a glitch.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q     <= '0;
                        shift_q   <= {rxd_s_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (rxd_s_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BRK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_BRK: begin
                    // A held-low line must go high before a new start bit counts.
                    if (rxd_s_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // A completing frame beats a concurrent ACK; the ACK retires the old byte.
            if (done_q) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
                if (valid_q && rx_if.ack) begin
                    overrun_q <= 1'b0;
                end else if (valid_q) begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && rx_if.ack) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign rx_if.data      = data_q;
    assign rx_if.valid     = valid_q;
    assign rx_if.overrun   = overrun_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: good frames, glitch,
// framing error with held-low line, overrun, ACK/completion race, mid-frame reset.
module tb_uart_rx;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   rise_cyc = 0;
    int   fe_cnt   = 0;
    int   busy_cnt = 0;
    logic valid_prev = 1'b0;

    uart_rx_if u_if ();

    uart_rx #(.CLKS_PER_BIT(CPB)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .rx_if (u_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor sampled on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        valid_prev <= u_if.valid;
        if (u_if.valid && !valid_prev) rise_cyc <= cyc;
        if (u_if.frame_err) fe_cnt <= fe_cnt + 1;
        if (u_if.busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_pulse();
        u_if.ack = 1'b1;
        @(posedge clk);
        #1;
        u_if.ack = 1'b0;
    endtask

    // Drives one 10-bit frame starting just after a rising edge. ack_at / rst_at
    // give the cycle offset (from the start-bit edge) for a one-cycle ACK or a reset.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int ack_at, input int rst_at, output int t0);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        t0 = cyc;
        for (int c = 0; c < 10 * CPB; c++) begin
            u_if.rxd = frame[c / CPB];
            u_if.ack = (c == ack_at);
            if (c == rst_at) begin
                check("busy_before_rst", u_if.busy, 1);
                rst = 1'b1;
                #1;
                check("rst_mid_data", u_if.data, 8'h00);
                check("rst_mid_valid", u_if.valid, 0);
                check("rst_mid_busy", u_if.busy, 0);
                check("rst_mid_ovr", u_if.overrun, 0);
            end
            if (c == rst_at + 2) rst = 1'b0;
            @(posedge clk);
            #1;
        end
        u_if.ack = 1'b0;
    endtask

    initial begin
        int t0;
        int fe_base;
        int busy_base;
        int d;

        u_if.rxd = 1'b1;
        u_if.ack = 1'b0;
        idle(3);
        check("rst_data", u_if.data, 8'h00);
        check("rst_valid", u_if.valid, 0);
        check("rst_ovr", u_if.overrun, 0);
        check("rst_fe", u_if.frame_err, 0);
        check("rst_busy", u_if.busy, 0);
        rst = 1'b0;
        idle(4);

        // Clean 0xA5 frame; VALID rises one cycle after the stop-bit sample.
        fe_base = fe_cnt;
        send_frame(8'hA5, 1'b1, -1, -1, t0);
        u_if.rxd = 1'b1;
        idle(4);
        check("a5_data", u_if.data, 8'hA5);
        check("a5_valid", u_if.valid, 1);
        check("a5_ovr", u_if.overrun, 0);
        check("a5_fe", fe_cnt - fe_base, 0);
        check("a5_latency", rise_cyc - t0, 156);
        ack_pulse();
        check("a5_ack_valid", u_if.valid, 0);

        // 5-cycle low glitch, shorter than half a bit.
        fe_base   = fe_cnt;
        busy_base = busy_cnt;
        u_if.rxd = 1'b0;
        idle(5);
        u_if.rxd = 1'b1;
        idle(20);
        d = busy_cnt - busy_base;
        check("glitch_busy_len", (d > 0) && (d <= 10), 1);
        check("glitch_busy_now", u_if.busy, 0);
        check("glitch_valid", u_if.valid, 0);
        check("glitch_fe", fe_cnt - fe_base, 0);

        // 0x3C with a low stop bit, line held low for 40 more cycles.
        fe_base = fe_cnt;
        send_frame(8'h3C, 1'b0, -1, -1, t0);
        u_if.rxd = 1'b0;
        idle(40);
        check("brk_busy_hold", u_if.busy, 1);
        check("brk_fe_pulse", fe_cnt - fe_base, 1);
        check("brk_valid", u_if.valid, 0);
        check("brk_data", u_if.data, 8'hA5);
        u_if.rxd = 1'b1;
        idle(4);
        check("brk_release_busy", u_if.busy, 0);
        idle(30);
        check("brk_no_retrigger", u_if.valid, 0);
        check("brk_fe_single", fe_cnt - fe_base, 1);
        send_frame(8'h55, 1'b1, -1, -1, t0);
        u_if.rxd = 1'b1;
        idle(4);
        check("x55_data", u_if.data, 8'h55);
        check("x55_valid", u_if.valid, 1);
        ack_pulse();

        // Overrun: two frames without an ACK.
        send_frame(8'h11, 1'b1, -1, -1, t0);
        u_if.rxd = 1'b1;
        idle(4);
        check("ovr_first_data", u_if.data, 8'h11);
        check("ovr_first_flag", u_if.overrun, 0);
        send_frame(8'h22, 1'b1, -1, -1, t0);
        u_if.rxd = 1'b1;
        idle(4);
        check("ovr_data", u_if.data, 8'h22);
        check("ovr_valid", u_if.valid, 1);
        check("ovr_flag", u_if.overrun, 1);
        ack_pulse();
        check("ovr_ack_valid", u_if.valid, 0);
        check("ovr_ack_flag", u_if.overrun, 0);

        // ACK lands on the very edge the second byte is delivered.
        send_frame(8'h11, 1'b1, -1, -1, t0);
        u_if.rxd = 1'b1;
        idle(4);
        send_frame(8'h22, 1'b1, 155, -1, t0);
        u_if.rxd = 1'b1;
        idle(4);
        check("race_data", u_if.data, 8'h22);
        check("race_valid", u_if.valid, 1);
        check("race_ovr", u_if.overrun, 0);

        // Reset during data bit 4 of 0xFF, then a clean 0x81.
        send_frame(8'hFF, 1'b1, -1, 88, t0);
        u_if.rxd = 1'b1;
        idle(10);
        check("post_rst_valid", u_if.valid, 0);
        check("post_rst_busy", u_if.busy, 0);
        send_frame(8'h81, 1'b1, -1, -1, t0);
        u_if.rxd = 1'b1;
        idle(4);
        check("x81_data", u_if.data, 8'h81);
        check("x81_valid", u_if.valid, 1);
        check("x81_ovr", u_if.overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
